// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the dmem load/store adapter.
// - size_e     : access size encoding on the request bus (3 = illegal)
// - req_t      : one queued request as held in the request FIFO
// - lane_mask  : byte lanes touched by an access
// - misaligned : access cannot be issued (bad alignment or illegal size)
// LSU_ADDR_W / LSU_TAG_W size req_t and must match the ADDR_WIDTH /
// TAG_WIDTH parameters used on the adapter and its interface.
package dmem_lsu_pkg;

    localparam int LSU_ADDR_W = 10;
    localparam int LSU_TAG_W  = 4;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // size is kept as raw bits so the illegal encoding 3 can be queued and reported
    typedef struct packed {
        logic                  is_st;
        logic [1:0]            size;
        logic                  is_unsigned;
        logic [LSU_ADDR_W+1:0] addr;
        logic [31:0]           data;
        logic [LSU_TAG_W-1:0]  tag;
    } req_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    // Illegal size is folded in here so the issue logic has a single error term.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lsu_adapter_if.sv
// Bus bundle for dmem_lsu_adapter: core request channel, response channel
// and the dmem_ext memory port.
// - slave  : adapter view (takes requests, produces responses, drives memory)
// - master : environment view (core pipeline plus memory macro)
interface dmem_lsu_adapter_if
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_ADDR_W,
    parameter int TAG_WIDTH  = LSU_TAG_W
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_is_st;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_data;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [TAG_WIDTH-1:0]  rsp_tag;
    logic                  rsp_err;

    logic                  dmem_valid_st;
    logic                  dmem_spec_ld;
    logic [3:0]            dmem_we;
    logic [ADDR_WIDTH-1:0] dmem_addr;
    logic [31:0]           dmem_din;
    logic [31:0]           dmem_dout;

    modport slave (
        input  req_valid, req_is_st, req_size, req_unsigned, req_addr, req_data, req_tag,
        input  rsp_ready, dmem_dout,
        output req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
        output dmem_valid_st, dmem_spec_ld, dmem_we, dmem_addr, dmem_din
    );

    modport master (
        output req_valid, req_is_st, req_size, req_unsigned, req_addr, req_data, req_tag,
        output rsp_ready, dmem_dout,
        input  req_ready, rsp_valid, rsp_data, rsp_tag, rsp_err,
        input  dmem_valid_st, dmem_spec_ld, dmem_we, dmem_addr, dmem_din
    );

endinterface

// File: rtl/dmem_lsu_fifo.sv
// Synchronous request FIFO for the load/store adapter.
// Ports: clk, reset (sync, active-high), push/push_data, pop, head (entry at
// the read pointer), full, empty. Push while full and pop while empty are
// ignored. DEPTH must be a power of two so the pointers wrap naturally.
module dmem_lsu_fifo
    import dmem_lsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    req_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dmem_lsu_adapter.sv
// Load/store adapter in front of the dmem_ext macro.
// Ports: clk, reset (sync, active-high), bus (dmem_lsu_adapter_if.slave)
// carrying the core request channel, the response channel and the memory port.
// Requests are queued in dmem_lsu_fifo; the head issues one memory access per
// cycle whenever the response register is free or being drained, and the
// response register is loaded at the same edge the head is popped.
module dmem_lsu_adapter
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_ADDR_W,
    parameter int DEPTH      = 2,
    parameter int TAG_WIDTH  = LSU_TAG_W
) (
    input  logic              clk,
    input  logic              reset,
    dmem_lsu_adapter_if.slave bus
);

    req_t                 push_req;
    req_t                 head;
    logic                 fifo_full, fifo_empty;
    logic                 issue, req_err, st_go, ld_go;
    logic [3:0]           mask;
    logic [31:0]          st_data, shifted, ld_data;

    logic                 rsp_valid_q, rsp_valid_d;
    logic [31:0]          rsp_data_q,  rsp_data_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q,   rsp_tag_d;
    logic                 rsp_err_q,   rsp_err_d;

    // Narrow loads: take the low byte/half of the shifted word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                                input logic [1:0]  size,
                                                input logic        zext);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = raw[7:0];
        h = raw[15:0];
        case (size)
            SZ_B: begin
                s = b;
                return zext ? {24'd0, raw[7:0]} : s;
            end
            SZ_H: begin
                s = h;
                return zext ? {16'd0, raw[15:0]} : s;
            end
            default: return raw;
        endcase
    endfunction

    always_comb begin
        push_req             = '0;
        push_req.is_st       = bus.req_is_st;
        push_req.size        = bus.req_size;
        push_req.is_unsigned = bus.req_unsigned;
        push_req.addr        = bus.req_addr;
        push_req.data        = bus.req_data;
        push_req.tag         = bus.req_tag;
    end

    // req_ready depends only on occupancy: a full FIFO refuses even if it pops this cycle.
    assign bus.req_ready = !fifo_full;

    dmem_lsu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.req_valid && !fifo_full),
        .push_data (push_req),
        .pop       (issue),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        // reset gates issue so no memory strobe can fire during a reset cycle
        issue   = !fifo_empty && (!rsp_valid_q || bus.rsp_ready) && !reset;
        req_err = misaligned(head.size, head.addr[1:0]);
        st_go   = issue && !req_err && head.is_st;
        ld_go   = issue && !req_err && !head.is_st;
        mask    = lane_mask(head.size, head.addr[1:0]);

        // Replicate the right-justified store data so every enabled lane sees it.
        case (head.size)
            SZ_B:    st_data = {4{head.data[7:0]}};
            SZ_H:    st_data = {2{head.data[15:0]}};
            default: st_data = head.data;
        endcase

        bus.dmem_valid_st = st_go;
        bus.dmem_spec_ld  = ld_go;
        bus.dmem_we       = st_go ? mask : 4'b0000;
        bus.dmem_din      = st_go ? st_data : 32'd0;
        bus.dmem_addr     = head.addr[ADDR_WIDTH+1:2];

        shifted = bus.dmem_dout >> {head.addr[1:0], 3'b000};
        ld_data = extend_load(shifted, head.size, head.is_unsigned);
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        if (issue) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = head.tag;
            rsp_err_d   = req_err;
            rsp_data_d  = (req_err || head.is_st) ? 32'd0 : ld_data;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // ---- response register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_lsu_adapter.sv
// Bench for dmem_lsu_adapter: byte-level reference memory plus an in-order
// request queue model, compared against the DUT every cycle, with literal
// expectations for the directed scenarios.
module tb_dmem_lsu_adapter;

    localparam int AW    = 10;
    localparam int DEPTH = 2;
    localparam int TW    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_lsu_adapter_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    dmem_lsu_adapter #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic started = 1'b0;

    // ---------------- memory macro model (dmem_ext) ----------------
    logic [31:0] ext_mem [1<<AW];
    logic [7:0]  ref_mem [4<<AW];
    assign bus.dmem_dout = ext_mem[bus.dmem_addr];

    initial begin
        for (int b = 0; b < (4 << AW); b++) begin
            logic [7:0] v;
            v = 8'(b) ^ 8'h5A;
            ref_mem[b] = v;
            ext_mem[b / 4][8 * (b % 4) +: 8] = v;
        end
        forever begin
            @(posedge clk);
            if (bus.dmem_valid_st)
                for (int k = 0; k < 4; k++)
                    if (bus.dmem_we[k]) ext_mem[bus.dmem_addr][8 * k +: 8] = bus.dmem_din[8 * k +: 8];
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic          is_st;
        logic [1:0]    size;
        logic          uns;
        logic [AW+1:0] addr;
        logic [31:0]   data;
        logic [TW-1:0] tag;
    } tb_req_t;

    function automatic logic bad_req(input tb_req_t r);
        return (r.size == 2'd3) || (r.size == 2'd1 && r.addr[0]) || (r.size == 2'd2 && r.addr[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input tb_req_t r);
        int a;
        logic [31:0] v;
        a = int'(r.addr);
        if (r.size == 2'd0) begin
            v = {24'd0, ref_mem[a]};
            if (!r.uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (r.size == 2'd1) begin
            v = {16'd0, ref_mem[a+1], ref_mem[a]};
            if (!r.uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
        end
        return v;
    endfunction

    task automatic ref_store(input tb_req_t r);
        int a;
        int n;
        a = int'(r.addr);
        n = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[a + i] = r.data[8 * i +: 8];
    endtask

    function automatic logic [3:0] exp_mask(input tb_req_t r);
        if (r.size == 2'd0) return 4'(1 << r.addr[1:0]);
        if (r.size == 2'd1) return 4'(3 << r.addr[1:0]);
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_din(input tb_req_t r);
        if (r.size == 2'd0) return {4{r.data[7:0]}};
        if (r.size == 2'd1) return {2{r.data[15:0]}};
        return r.data;
    endfunction

    // ---------------- behavioural model ----------------
    tb_req_t       pending[$];
    logic          m_valid = 1'b0;
    logic [31:0]   m_data  = '0;
    logic [TW-1:0] m_tag   = '0;
    logic          m_err   = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
        started = 1'b1;
        if (reset) begin
            pending.delete();
            m_valid = 1'b0;
            m_data  = '0;
            m_tag   = '0;
            m_err   = 1'b0;
        end else begin
            logic    do_issue, do_acc;
            tb_req_t r, n;
            do_acc   = bus.req_valid && (pending.size() < DEPTH);
            do_issue = (pending.size() > 0) && (!m_valid || bus.rsp_ready);
            if (do_issue) begin
                r       = pending.pop_front();
                m_valid = 1'b1;
                m_tag   = r.tag;
                m_err   = bad_req(r);
                m_data  = (m_err || r.is_st) ? 32'd0 : ref_load(r);
                if (!m_err && r.is_st) ref_store(r);
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
            if (do_acc) begin
                n.is_st = bus.req_is_st;
                n.size  = bus.req_size;
                n.uns   = bus.req_unsigned;
                n.addr  = bus.req_addr;
                n.data  = bus.req_data;
                n.tag   = bus.req_tag;
                pending.push_back(n);
            end
        end
    end

    // ---------------- per-cycle compare and logging ----------------
    logic [31:0]   log_data[$];
    logic [TW-1:0] log_tag[$];
    logic          log_err[$];
    int            log_cyc[$];
    logic [3:0]    st_we[$];
    logic [31:0]   st_din[$];
    logic [AW-1:0] st_addr[$];
    int            strobe_cnt = 0;
    int            st_cnt     = 0;

    initial forever begin
        @(negedge clk);
        if (started) begin
            tb_req_t    h;
            logic       e_issue, e_err, e_st, e_ld;
            logic [3:0] e_we;
            logic [31:0] e_din;
            check("req_ready", bus.req_ready, pending.size() < DEPTH);
            check("rsp_valid", bus.rsp_valid, m_valid);
            if (m_valid) begin
                check("rsp_tag", bus.rsp_tag, m_tag);
                check("rsp_err", bus.rsp_err, m_err);
                check("rsp_data", bus.rsp_data, m_data);
            end
            e_issue = !reset && (pending.size() > 0) && (!m_valid || bus.rsp_ready);
            e_st = 1'b0; e_ld = 1'b0; e_we = 4'h0; e_din = 32'd0; e_err = 1'b0;
            if (e_issue) begin
                h     = pending[0];
                e_err = bad_req(h);
                e_st  = !e_err && h.is_st;
                e_ld  = !e_err && !h.is_st;
                if (e_st) begin
                    e_we  = exp_mask(h);
                    e_din = exp_din(h);
                end
                if (!e_err) check("dmem_addr", bus.dmem_addr, h.addr[AW+1:2]);
            end
            check("dmem_valid_st", bus.dmem_valid_st, e_st);
            check("dmem_spec_ld", bus.dmem_spec_ld, e_ld);
            check("dmem_we", bus.dmem_we, e_we);
            check("dmem_din", bus.dmem_din, e_din);
        end
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            log_data.push_back(bus.rsp_data);
            log_tag.push_back(bus.rsp_tag);
            log_err.push_back(bus.rsp_err);
            log_cyc.push_back(cyc);
        end
        if (bus.dmem_valid_st) begin
            st_we.push_back(bus.dmem_we);
            st_din.push_back(bus.dmem_din);
            st_addr.push_back(bus.dmem_addr);
            st_cnt++;
        end
        if (bus.dmem_valid_st || bus.dmem_spec_ld) strobe_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        log_data.delete(); log_tag.delete(); log_err.delete(); log_cyc.delete();
        st_we.delete(); st_din.delete(); st_addr.delete();
        strobe_cnt = 0;
        st_cnt     = 0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [AW+1:0] a, input logic [31:0] d, input logic [TW-1:0] t);
        logic acc;
        int   n;
        bus.req_valid    = 1'b1;
        bus.req_is_st    = st;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_data     = d;
        bus.req_tag      = t;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        bus.req_valid = 1'b0;
        check("send_accept", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string nm, input int idx, input logic [TW-1:0] t,
                           input logic e, input logic [31:0] d);
        check({nm, "_present"}, log_tag.size() > idx, 1'b1);
        if (log_tag.size() > idx) begin
            check({nm, "_tag"}, log_tag[idx], t);
            check({nm, "_err"}, log_err[idx], e);
            check({nm, "_data"}, log_data[idx], d);
        end
    endtask

    task automatic chk_st(input string nm, input int idx, input logic [3:0] we,
                          input logic [31:0] din, input logic [AW-1:0] a);
        check({nm, "_present"}, st_we.size() > idx, 1'b1);
        if (st_we.size() > idx) begin
            check({nm, "_we"}, st_we[idx], we);
            check({nm, "_din"}, st_din[idx], din);
            check({nm, "_addr"}, st_addr[idx], a);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        reset            = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_is_st    = 1'b0;
        bus.req_size     = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_data     = '0;
        bus.req_tag      = '0;
        bus.rsp_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 1'b0);
        check("rst_rsp_data", bus.rsp_data, 32'd0);
        check("rst_rsp_tag", bus.rsp_tag, 4'd0);
        check("rst_rsp_err", bus.rsp_err, 1'b0);
        check("rst_req_ready", bus.req_ready, 1'b1);
        check("rst_valid_st", bus.dmem_valid_st, 1'b0);
        check("rst_spec_ld", bus.dmem_spec_ld, 1'b0);
        check("rst_we", bus.dmem_we, 4'h0);
        @(posedge clk);
        #1;

        // word store then word load
        clear_logs();
        send(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, 4'd1);
        send(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 4'd2);
        idle(4);
        chk_st("w_st", 0, 4'hF, 32'hDEAD_BEEF, 10'd4);
        chk_rsp("w_st_ack", 0, 4'd1, 1'b0, 32'd0);
        chk_rsp("w_ld", 1, 4'd2, 1'b0, 32'hDEAD_BEEF);

        // byte store, signed and unsigned byte loads
        clear_logs();
        send(1'b1, 2'd0, 1'b0, 12'h013, 32'h0000_0080, 4'd3);
        send(1'b0, 2'd0, 1'b0, 12'h013, 32'd0, 4'd4);
        send(1'b0, 2'd0, 1'b1, 12'h013, 32'd0, 4'd5);
        idle(4);
        chk_st("b_st", 0, 4'h8, 32'h8080_8080, 10'd4);
        chk_rsp("b_st_ack", 0, 4'd3, 1'b0, 32'd0);
        chk_rsp("b_ld_s", 1, 4'd4, 1'b0, 32'hFFFF_FF80);
        chk_rsp("b_ld_u", 2, 4'd5, 1'b0, 32'h0000_0080);

        // misaligned requests
        clear_logs();
        send(1'b0, 2'd1, 1'b0, 12'h011, 32'd0, 4'd6);
        send(1'b1, 2'd2, 1'b0, 12'h012, 32'h1234_5678, 4'd7);
        idle(4);
        check("mis_strobes", strobe_cnt, 0);
        chk_rsp("mis_h_ld", 0, 4'd6, 1'b1, 32'd0);
        chk_rsp("mis_w_st", 1, 4'd7, 1'b1, 32'd0);

        // backpressure: one held response plus DEPTH queued
        clear_logs();
        bus.rsp_ready = 1'b0;
        send(1'b0, 2'd2, 1'b0, 12'h010, 32'd0, 4'd8);
        send(1'b0, 2'd0, 1'b1, 12'h013, 32'd0, 4'd9);
        send(1'b0, 2'd1, 1'b0, 12'h012, 32'd0, 4'd10);
        bus.req_valid    = 1'b1;
        bus.req_is_st    = 1'b0;
        bus.req_size     = 2'd1;
        bus.req_unsigned = 1'b1;
        bus.req_addr     = 12'h010;
        bus.req_tag      = 4'd11;
        @(negedge clk);
        check("bp_req_ready", bus.req_ready, 1'b0);
        check("bp_rsp_valid", bus.rsp_valid, 1'b1);
        check("bp_rsp_tag", bus.rsp_tag, 4'd8);
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_tag", bus.rsp_tag, 4'd8);
        check("bp_hold_data", bus.rsp_data, 32'h80AD_BEEF);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        send(1'b0, 2'd1, 1'b1, 12'h010, 32'd0, 4'd11);
        idle(5);
        chk_rsp("bp0", 0, 4'd8, 1'b0, 32'h80AD_BEEF);
        chk_rsp("bp1", 1, 4'd9, 1'b0, 32'h0000_0080);
        chk_rsp("bp2", 2, 4'd10, 1'b0, 32'hFFFF_80AD);
        chk_rsp("bp3", 3, 4'd11, 1'b0, 32'h0000_BEEF);

        // reset with queued stores
        bus.rsp_ready = 1'b0;
        send(1'b0, 2'd2, 1'b0, 12'h020, 32'd0, 4'd12);
        send(1'b1, 2'd2, 1'b0, 12'h020, 32'h1111_1111, 4'd13);
        send(1'b1, 2'd2, 1'b0, 12'h024, 32'h2222_2222, 4'd14);
        clear_logs();
        reset = 1'b1;
        @(negedge clk);
        check("rstq_valid_st", bus.dmem_valid_st, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rstq_rsp_valid", bus.rsp_valid, 1'b0);
        check("rstq_req_ready", bus.req_ready, 1'b1);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        idle(3);
        check("rstq_no_store", st_cnt, 0);
        send(1'b0, 2'd2, 1'b0, 12'h020, 32'd0, 4'd15);
        idle(4);
        chk_rsp("rstq_ld", 0, 4'd15, 1'b0, 32'h7978_7B7A);

        // back-to-back loads
        clear_logs();
        for (int i = 0; i < 8; i++) send(1'b0, 2'd2, 1'b0, 12'(12'h040 + 4 * i), 32'd0, 4'(i));
        idle(4);
        check("b2b_count", log_tag.size(), 8);
        if (log_tag.size() == 8) begin
            for (int i = 0; i < 8; i++) check("b2b_tag", log_tag[i], 4'(i));
            check("b2b_span", log_cyc[7] - log_cyc[0], 7);
            check("b2b_data0", log_data[0], 32'h1918_1B1A);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
